// File: rtl/rv32_exec_datapath.sv
// RV32I execution datapath: 32x32 register file with two async read ports and one
// write port, feeding a single-cycle integer ALU for OP and OP-IMM instructions.
module rv32_exec_datapath #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_write_enable,
    input  logic            i_use_imm,
    input  logic [XLEN-1:0] i_imm,
    input  logic [2:0]      i_alu_op,
    input  logic [6:0]      i_funct7,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic [XLEN-1:0] o_alu_result
);

    logic [XLEN-1:0] r_regs [NREGS];

    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [4:0]      w_shamt;
    logic            w_alt;
    logic            w_unused_funct7;

    assign w_unused_funct7 = ^{i_funct7[6], i_funct7[4:0]};
    assign w_alt           = i_funct7[5];

    // x0 is never written, but reads are gated as well so it is 0 by construction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_write_enable && (i_rd_addr != 5'd0)) begin
            r_regs[i_rd_addr] <= o_alu_result;
        end
    end

    assign o_rs1_data = (i_rs1_addr == 5'd0) ? '0 : r_regs[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == 5'd0) ? '0 : r_regs[i_rs2_addr];

    assign w_op_a  = o_rs1_data;
    assign w_op_b  = i_use_imm ? i_imm : o_rs2_data;
    assign w_shamt = w_op_b[4:0];

    // funct7[5] selects SUB only for the register form; the I-type immediate overlaps it.
    always_comb begin
        o_alu_result = '0;
        case (i_alu_op)
            3'b000: o_alu_result = (w_alt && !i_use_imm) ? (w_op_a - w_op_b) : (w_op_a + w_op_b);
            3'b001: o_alu_result = w_op_a << w_shamt;
            3'b010: o_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            3'b011: o_alu_result = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
            3'b100: o_alu_result = w_op_a ^ w_op_b;
            3'b101: o_alu_result = w_alt ? XLEN'($signed(w_op_a) >>> w_shamt) : (w_op_a >> w_shamt);
            3'b110: o_alu_result = w_op_a | w_op_b;
            3'b111: o_alu_result = w_op_a & w_op_b;
            default: o_alu_result = '0;
        endcase
    end

endmodule

// File: tb/tb_rv32_exec_datapath.sv
// Self-checking bench for rv32_exec_datapath: expected values are queued when
// stimulus is applied and popped when the DUT output is sampled.
module tb_rv32_exec_datapath;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
    logic        write_enable = 1'b0, use_imm = 1'b0;
    logic [31:0] imm = '0;
    logic [2:0]  alu_op = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] rs1_data, rs2_data, alu_result;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb_q [$];

    rv32_exec_datapath dut (
        .clk            (clk),
        .reset          (reset),
        .i_rs1_addr     (rs1_addr),
        .i_rs2_addr     (rs2_addr),
        .i_rd_addr      (rd_addr),
        .i_write_enable (write_enable),
        .i_use_imm      (use_imm),
        .i_imm          (imm),
        .i_alu_op       (alu_op),
        .i_funct7       (funct7),
        .o_rs1_data     (rs1_data),
        .o_rs2_data     (rs2_data),
        .o_alu_result   (alu_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] obs);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s scoreboard empty, got 0x%08h", tag, obs);
        end else begin
            chk(tag, obs, sb_q.pop_front());
        end
    endtask

    // Writes v into register r through ADDI rd, x0, v.
    task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
        @(negedge clk);
        rs1_addr = 5'd0; use_imm = 1'b1; imm = v; alu_op = 3'b000; funct7 = 7'h00;
        rd_addr = r; write_enable = 1'b1;
        @(posedge clk);
        #1 write_enable = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [6:0] f7,
                          input logic ui, input logic [31:0] im,
                          input logic [4:0] a, input logic [4:0] b, input logic [31:0] exp);
        @(negedge clk);
        write_enable = 1'b0;
        rs1_addr = a; rs2_addr = b; alu_op = op; funct7 = f7; use_imm = ui; imm = im;
        sb_q.push_back(exp);
        #1 pop_chk(tag, alu_result);
    endtask

    task automatic read_chk(input string tag, input logic [4:0] r, input logic [31:0] exp);
        @(negedge clk);
        write_enable = 1'b0;
        rs1_addr = r;
        sb_q.push_back(exp);
        #1 pop_chk(tag, rs1_data);
    endtask

    initial begin
        // Reset state
        rs1_addr = 5'd7; rs2_addr = 5'd9;
        repeat (2) @(negedge clk);
        sb_q.push_back(32'h0); sb_q.push_back(32'h0);
        #1;
        pop_chk("reset_rs1", rs1_data);
        pop_chk("reset_rs2", rs2_data);
        @(negedge clk);
        reset = 1'b0;

        // x0 and basic write-back
        @(negedge clk);
        rs1_addr = 5'd0; use_imm = 1'b1; imm = 32'd5; alu_op = 3'b000; rd_addr = 5'd0; write_enable = 1'b1;
        @(posedge clk);
        #1 write_enable = 1'b0;
        read_chk("x0_write_ignored", 5'd0, 32'h0);
        set_reg(5'd1, 32'd5);
        read_chk("x1_eq_5", 5'd1, 32'd5);

        // Register-register arithmetic and logic
        set_reg(5'd1, 32'd10);
        set_reg(5'd2, 32'd3);
        run_op("add",  3'b000, 7'h00, 1'b0, 32'h0, 5'd1, 5'd2, 32'd13);
        run_op("sub",  3'b000, 7'h20, 1'b0, 32'h0, 5'd1, 5'd2, 32'd7);
        run_op("sub_neg", 3'b000, 7'h20, 1'b0, 32'h0, 5'd2, 5'd1, 32'hFFFFFFF9);
        run_op("and",  3'b111, 7'h00, 1'b0, 32'h0, 5'd1, 5'd2, 32'd2);
        run_op("or",   3'b110, 7'h00, 1'b0, 32'h0, 5'd1, 5'd2, 32'd11);
        run_op("xor",  3'b100, 7'h00, 1'b0, 32'h0, 5'd1, 5'd2, 32'd9);
        run_op("addi_guard", 3'b000, 7'h20, 1'b1, 32'hFFFFFC00, 5'd1, 5'd2, 32'hFFFFFC0A);

        // Signed vs unsigned compares
        set_reg(5'd1, 32'hFFFFFFFF);
        set_reg(5'd2, 32'd1);
        run_op("slt_neg_lt",   3'b010, 7'h00, 1'b0, 32'h0, 5'd1, 5'd2, 32'd1);
        run_op("sltu_big",     3'b011, 7'h00, 1'b0, 32'h0, 5'd1, 5'd2, 32'd0);
        run_op("slt_pos",      3'b010, 7'h00, 1'b0, 32'h0, 5'd2, 5'd1, 32'd0);
        run_op("sltu_small",   3'b011, 7'h00, 1'b0, 32'h0, 5'd2, 5'd1, 32'd1);
        run_op("slt_equal",    3'b010, 7'h00, 1'b0, 32'h0, 5'd1, 5'd1, 32'd0);
        run_op("sltu_equal",   3'b011, 7'h00, 1'b0, 32'h0, 5'd1, 5'd1, 32'd0);

        // Shifts: only B[4:0] counts
        set_reg(5'd1, 32'h80000010);
        set_reg(5'd2, 32'h00000024);
        run_op("sll",      3'b001, 7'h00, 1'b1, 32'h24, 5'd1, 5'd2, 32'h00000100);
        run_op("srl",      3'b101, 7'h00, 1'b1, 32'h24, 5'd1, 5'd2, 32'h08000001);
        run_op("sra",      3'b101, 7'h20, 1'b1, 32'h24, 5'd1, 5'd2, 32'hF8000001);
        run_op("sra_reg",  3'b101, 7'h20, 1'b0, 32'h0,  5'd1, 5'd2, 32'hF8000001);
        run_op("srl_zero", 3'b101, 7'h00, 1'b1, 32'h20, 5'd1, 5'd2, 32'h80000010);
        run_op("sll_zero", 3'b001, 7'h00, 1'b1, 32'h0,  5'd1, 5'd2, 32'h80000010);

        // Read-during-write has no bypass
        set_reg(5'd3, 32'h11);
        @(negedge clk);
        rs1_addr = 5'd3; rd_addr = 5'd3; use_imm = 1'b1; imm = 32'h22; alu_op = 3'b000;
        funct7 = 7'h00; write_enable = 1'b1;
        sb_q.push_back(32'h11);
        #1 pop_chk("rdw_old", rs1_data);
        @(posedge clk);
        sb_q.push_back(32'h33);
        #1 pop_chk("rdw_new", rs1_data);
        write_enable = 1'b0;

        // Asynchronous reset mid-cycle, and writes blocked during reset
        set_reg(5'd5, 32'h1234);
        read_chk("x5_set", 5'd5, 32'h1234);
        @(negedge clk);
        #2 reset = 1'b1;
        rs2_addr = 5'd5; use_imm = 1'b0; alu_op = 3'b000; funct7 = 7'h00;
        sb_q.push_back(32'h0); sb_q.push_back(32'h0);
        #1;
        pop_chk("reset_async_x5", rs1_data);
        pop_chk("reset_alu", alu_result);
        rd_addr = 5'd6; use_imm = 1'b1; imm = 32'h55; write_enable = 1'b1;
        @(posedge clk);
        #1 write_enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        read_chk("write_in_reset", 5'd6, 32'h0);
        read_chk("x5_after_reset", 5'd5, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
